pipelined_divider: RTL and testbench
====================================

// Module: pipelined_divider
// PURPOSE
//  Native, fully pipelined signed integer divider with parametrised widths.
//  Accepts one dividend/divisor pair per cycle and returns quotient, remainder and
//  exception flags after a fixed, known latency.
//  Carries a side-band tag through the pipeline.
//  Sits in the rx datapath wherever a per-sample ratio is needed, e.g. phase/CFO
//  normalisation and channel equalisation.
// PARAMETERS
//  DIVIDEND_WIDTH  32  signed dividend width; also quotient and remainder width
//  DIVISOR_WIDTH   24  signed divisor width, must be <= DIVIDEND_WIDTH
//  TAG_WIDTH       8   side-band tag width, passed through unchanged
// PORTS
//  clock          in   1               rising-edge clock
//  reset_n        in   1               asynchronous, active-low reset
//  enable         in   1               pipeline advance; low = whole pipeline holds
//  dividend       in   DIVIDEND_WIDTH  signed, two's complement
//  divisor        in   DIVISOR_WIDTH   signed, two's complement
//  input_tag      in   TAG_WIDTH       captured with the operands
//  input_strobe   in   1               operands valid this cycle
//  quotient       out  DIVIDEND_WIDTH  signed; truncated toward zero
//  remainder      out  DIVIDEND_WIDTH  signed; sign follows dividend
//  output_tag     out  TAG_WIDTH       tag of the result presented
//  div_by_zero    out  1               result came from divisor == 0
//  overflow       out  1               result came from MIN / -1
//  output_strobe  out  1               result valid this cycle
// BEHAVIOUR
//  - Reset: all stage valid bits cleared; every output is 0 while reset_n is low
//    and until the first result emerges. Reset mid-flight discards all in-flight
//    operations; no strobe follows from them.
//  - Operand capture: a pair is captured only when input_strobe & enable.
//    input_strobe while enable is low is dropped, not queued.
//  - Latency: LATENCY = DIVIDEND_WIDTH + 2 enabled cycles from capture to
//    output_strobe. Stalled cycles (enable low) do not count.
//    Throughput is 1 result per enabled cycle; back-to-back strobes give
//    back-to-back results in order.
//  - Pipeline stages:
//    - Stage 0: register |dividend|, |divisor| (sign-extended to DIVIDEND_WIDTH+1
//      bits), both sign bits, the tag, zero and MIN/-1 detection.
//    - Stages 1..DIVIDEND_WIDTH: one restoring step each, MSB first.
//      partial = {rem, next bit}; if partial >= |divisor| then subtract and set
//      q bit to 1.
//    - Final stage: negate q if signs differ; negate r if the dividend is
//      negative; apply exception overrides; register all outputs.
//  - Exceptions (override the computed value):
//    - divisor == 0: quotient = MAX (2^(W-1)-1) if dividend >= 0, else
//      MIN (-2^(W-1)); remainder = dividend; div_by_zero = 1.
//    - dividend == MIN and divisor == -1: quotient = MAX, remainder = 0,
//      overflow = 1.
//    - Both flags are never set together. Flags are qualified by output_strobe.
//  - Stall:
//    - enable low freezes every stage register, including output registers.
//    - output_strobe = last-stage valid & enable, so a held result is
//      strobed exactly once.
//    - quotient, remainder, output_tag and the flags stay stable while stalled.
//  - No internal state beyond the pipeline; no FSM; there is no backpressure
//    other than enable.
// STRUCTURE
//  - Shared package divider_pkg:
//    - function div_latency(W) = W + 2
//    - functions sat_max(W) and sat_min(W)
//    - localparam default widths
//  - Sub-module div_stage: one restoring step.
//    - Inputs: rem, dividend shift register, divisor, q, tag, flags, valid.
//    - Registered outputs: the same fields advanced by one step.
//    - Instantiated DIVIDEND_WIDTH times in a generate loop.
//  - The top level holds stage 0, the final stage, and the enable/valid chain.
// TESTING
//  1. 100 / 7, tag 0x11, enable high -> 34 cycles later: quotient 14, remainder 2,
//     tag 0x11, flags 0.
//  2. -100 / 7 -> quotient -14, remainder -2.
//     100 / -7 -> quotient -14, remainder 2.
//     -100 / -7 -> quotient 14, remainder -2.
//  3. 5 / 0 -> quotient 0x7FFFFFFF, remainder 5, div_by_zero 1.
//     -5 / 0 -> quotient 0x80000000, div_by_zero 1.
//     0x80000000 / -1 -> quotient 0x7FFFFFFF, overflow 1.
//  4. 2000 back-to-back random pairs (corners included: +/-1, MIN, max divisor)
//     -> results in order, one per cycle, bit-exact against a C-semantics model.
//  5. Random 30% enable-low gaps plus strobes during stalls
//     -> stalled-cycle inputs are dropped, each accepted pair yields exactly one
//     strobe, and outputs are stable during stalls.
//  6. Assert reset_n low with 10 ops in flight, release, send 9 / 3
//     -> no stale strobes; the single result is 3 after 34 cycles.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the pipelined signed divider: default widths,
// latency and saturation helpers, and the per-operation flag bundle.
package divider_pkg;
    localparam int DEF_DIVIDEND_WIDTH = 32;
    localparam int DEF_DIVISOR_WIDTH  = 24;
    localparam int DEF_TAG_WIDTH      = 8;
    localparam int SAT_BITS           = 64;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
        logic div_zero;
        logic ovf;
    } div_flags_t;

    function automatic int div_latency(input int w);
        return w + 2;
    endfunction

    function automatic logic [SAT_BITS-1:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [SAT_BITS-1:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/div_stage.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder, subtracts the divisor when it fits and appends the quotient bit.
module div_stage
    import divider_pkg::*;
#(
    parameter int W     = DEF_DIVIDEND_WIDTH,
    parameter int TAG_W = DEF_TAG_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             valid,
    input  logic [W-1:0]     rem,
    input  logic [W-1:0]     num,
    input  logic [W:0]       den,
    input  logic [W-1:0]     quot,
    input  logic [TAG_W-1:0] tag,
    input  div_flags_t       flags,
    output logic             valid_r,
    output logic [W-1:0]     rem_r,
    output logic [W-1:0]     num_r,
    output logic [W:0]       den_r,
    output logic [W-1:0]     quot_r,
    output logic [TAG_W-1:0] tag_r,
    output div_flags_t       flags_r
);
    logic [W:0]   partial_s;
    logic         fits_s;
    logic [W-1:0] rem_next_s;

    // Trial subtraction of the divisor from the extended partial remainder
    always_comb begin
        partial_s = {rem, num[W-1]};
        fits_s    = (partial_s >= den);
        if (fits_s) begin
            rem_next_s = W'(partial_s - den);
        end else begin
            rem_next_s = partial_s[W-1:0];
        end
    end

    // Step registers; the whole stage holds while enable is low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            rem_r   <= {W{1'b0}};
            num_r   <= {W{1'b0}};
            den_r   <= {(W+1){1'b0}};
            quot_r  <= {W{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
            flags_r <= div_flags_t'(4'b0000);
        end else if (enable) begin
            valid_r <= valid;
            rem_r   <= rem_next_s;
            num_r   <= num << 1'b1;
            den_r   <= den;
            quot_r  <= (quot << 1'b1) | {{(W-1){1'b0}}, fits_s};
            tag_r   <= tag;
            flags_r <= flags;
        end
    end
endmodule

// File: rtl/pipelined_divider.sv
// Fully pipelined signed divider: operand conditioning stage, one restoring
// step per dividend bit, and a sign-fixup / exception stage feeding the outputs.
module pipelined_divider
    import divider_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic [TAG_WIDTH-1:0]      input_tag,
    input  logic                      input_strobe,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVIDEND_WIDTH-1:0] remainder,
    output logic [TAG_WIDTH-1:0]      output_tag,
    output logic                      div_by_zero,
    output logic                      overflow,
    output logic                      output_strobe
);
    localparam int W     = DIVIDEND_WIDTH;
    localparam int DVW   = DIVISOR_WIDTH;
    localparam int TW    = TAG_WIDTH;
    localparam int STEPS = div_latency(W) - 2;
    localparam logic [W-1:0] Q_MAX = W'(sat_max(W));
    localparam logic [W-1:0] Q_MIN = W'(sat_min(W));

    logic         dividend_neg_s;
    logic         divisor_neg_s;
    logic         div_zero_s;
    logic         ovf_s;
    logic [W-1:0] dividend_abs_s;
    logic [W:0]   divisor_ext_s;
    logic [W:0]   divisor_abs_s;

    logic         valid0_r;
    logic [W-1:0] num0_r;
    logic [W:0]   den0_r;
    logic [TW-1:0] tag0_r;
    div_flags_t   flags0_r;

    logic          stage_valid_s [0:STEPS];
    logic [W-1:0]  stage_rem_s   [0:STEPS];
    logic [W-1:0]  stage_num_s   [0:STEPS];
    logic [W:0]    stage_den_s   [0:STEPS];
    logic [W-1:0]  stage_quot_s  [0:STEPS];
    logic [TW-1:0] stage_tag_s   [0:STEPS];
    div_flags_t    stage_flags_s [0:STEPS];

    logic [W-1:0] q_signed_s;
    logic [W-1:0] r_signed_s;
    logic [W-1:0] q_final_s;
    logic [W-1:0] r_final_s;

    logic          out_valid_r;
    logic [W-1:0]  quotient_r;
    logic [W-1:0]  remainder_r;
    logic [TW-1:0] output_tag_r;
    logic          div_by_zero_r;
    logic          overflow_r;

    // Operand magnitudes and exception detection ahead of stage 0
    always_comb begin
        dividend_neg_s = dividend[W-1];
        divisor_neg_s  = divisor[DVW-1];
        div_zero_s     = (divisor == {DVW{1'b0}});
        ovf_s          = (dividend == Q_MIN) && (divisor == {DVW{1'b1}});
        dividend_abs_s = dividend_neg_s ? (-dividend) : dividend;
        divisor_ext_s  = {{(W+1-DVW){divisor[DVW-1]}}, divisor};
        // An all-ones divisor never fits, so a zero divisor leaves q = 0 and
        // r = |dividend|, which the final stage turns back into the dividend.
        if (div_zero_s) begin
            divisor_abs_s = {(W+1){1'b1}};
        end else begin
            divisor_abs_s = divisor_neg_s ? (-divisor_ext_s) : divisor_ext_s;
        end
    end

    // Stage 0 registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid0_r <= 1'b0;
            num0_r   <= {W{1'b0}};
            den0_r   <= {(W+1){1'b0}};
            tag0_r   <= {TW{1'b0}};
            flags0_r <= div_flags_t'(4'b0000);
        end else if (enable) begin
            valid0_r <= input_strobe;
            num0_r   <= dividend_abs_s;
            den0_r   <= divisor_abs_s;
            tag0_r   <= input_tag;
            flags0_r <= '{neg_q: dividend_neg_s ^ divisor_neg_s, neg_r: dividend_neg_s,
                          div_zero: div_zero_s, ovf: ovf_s};
        end
    end

    assign stage_valid_s[0] = valid0_r;
    assign stage_rem_s[0]   = {W{1'b0}};
    assign stage_num_s[0]   = num0_r;
    assign stage_den_s[0]   = den0_r;
    assign stage_quot_s[0]  = {W{1'b0}};
    assign stage_tag_s[0]   = tag0_r;
    assign stage_flags_s[0] = flags0_r;

    for (genvar i = 1; i <= STEPS; i++) begin : g_step
        div_stage #(.W(W), .TAG_W(TW)) u_step (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (enable),
            .valid   (stage_valid_s[i-1]),
            .rem     (stage_rem_s[i-1]),
            .num     (stage_num_s[i-1]),
            .den     (stage_den_s[i-1]),
            .quot    (stage_quot_s[i-1]),
            .tag     (stage_tag_s[i-1]),
            .flags   (stage_flags_s[i-1]),
            .valid_r (stage_valid_s[i]),
            .rem_r   (stage_rem_s[i]),
            .num_r   (stage_num_s[i]),
            .den_r   (stage_den_s[i]),
            .quot_r  (stage_quot_s[i]),
            .tag_r   (stage_tag_s[i]),
            .flags_r (stage_flags_s[i])
        );
    end

    // The last step's divisor and exhausted dividend are not needed downstream
    logic unused_tail_s;
    assign unused_tail_s = ^{stage_den_s[STEPS], stage_num_s[STEPS]};

    // Sign restoration and exception overrides
    always_comb begin
        q_signed_s = stage_flags_s[STEPS].neg_q ? (-stage_quot_s[STEPS]) : stage_quot_s[STEPS];
        r_signed_s = stage_flags_s[STEPS].neg_r ? (-stage_rem_s[STEPS]) : stage_rem_s[STEPS];
        if (stage_flags_s[STEPS].div_zero) begin
            q_final_s = stage_flags_s[STEPS].neg_r ? Q_MIN : Q_MAX;
            r_final_s = r_signed_s;
        end else if (stage_flags_s[STEPS].ovf) begin
            q_final_s = Q_MAX;
            r_final_s = {W{1'b0}};
        end else begin
            q_final_s = q_signed_s;
            r_final_s = r_signed_s;
        end
    end

    // Output registers load only on a valid result so bubbles keep the last one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r   <= 1'b0;
            quotient_r    <= {W{1'b0}};
            remainder_r   <= {W{1'b0}};
            output_tag_r  <= {TW{1'b0}};
            div_by_zero_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else if (enable) begin
            out_valid_r <= stage_valid_s[STEPS];
            if (stage_valid_s[STEPS]) begin
                quotient_r    <= q_final_s;
                remainder_r   <= r_final_s;
                output_tag_r  <= stage_tag_s[STEPS];
                div_by_zero_r <= stage_flags_s[STEPS].div_zero;
                overflow_r    <= stage_flags_s[STEPS].ovf;
            end
        end
    end

    assign quotient      = quotient_r;
    assign remainder     = remainder_r;
    assign output_tag    = output_tag_r;
    assign div_by_zero   = div_by_zero_r;
    assign overflow      = overflow_r;
    assign output_strobe = out_valid_r & enable;
endmodule

// File: tb/tb_pipelined_divider.sv
// Self-checking bench for pipelined_divider: directed vector table, random
// back-to-back traffic, random stalls and a reset with operations in flight.
module tb_pipelined_divider;
    import divider_pkg::*;

    localparam int W   = 32;
    localparam int DVW = 24;
    localparam int TW  = 8;
    localparam int LAT = div_latency(W);
    localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable = 1'b0;
    logic [W-1:0]   dividend = 32'd0;
    logic [DVW-1:0] divisor = 24'd0;
    logic [TW-1:0]  input_tag = 8'd0;
    logic           input_strobe = 1'b0;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic [TW-1:0]  output_tag;
    logic           div_by_zero;
    logic           overflow;
    logic           output_strobe;

    pipelined_divider #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(DVW), .TAG_WIDTH(TW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .dividend      (dividend),
        .divisor       (divisor),
        .input_tag     (input_tag),
        .input_strobe  (input_strobe),
        .quotient      (quotient),
        .remainder     (remainder),
        .output_tag    (output_tag),
        .div_by_zero   (div_by_zero),
        .overflow      (overflow),
        .output_strobe (output_strobe)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          dbz;
        logic          ovf;
        int            due;
    } exp_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [DVW-1:0] b;
        logic [TW-1:0]  tag;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dbz;
        logic           ovf;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur_e;
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;

    logic [W-1:0]  prev_q, prev_r;
    logic [TW-1:0] prev_tag;
    logic          prev_dbz, prev_ovf;
    logic          prev_en = 1'b1;
    logic          prev_rst = 1'b0;

    always @(posedge clock) if (enable) en_cnt++;

    // C-semantics reference: truncating division, remainder follows dividend
    function automatic exp_t model(input logic [W-1:0] a, input logic [DVW-1:0] b, input logic [TW-1:0] tag);
        exp_t e;
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = {{(W-DVW){b[DVW-1]}}, b};
        e.tag = tag; e.dbz = 1'b0; e.ovf = 1'b0; e.due = 0;
        if (sb == 32'sd0) begin
            e.q = sa[W-1] ? MINV : MAXV; e.r = a; e.dbz = 1'b1;
        end else if (a == MINV && sb == -32'sd1) begin
            e.q = MAXV; e.r = 32'd0; e.ovf = 1'b1;
        end else begin
            e.q = sa / sb; e.r = sa % sb;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick_a();
        case ($urandom_range(0, 7))
            0: return MINV;
            1: return MAXV;
            2: return 32'd1;
            3: return 32'hFFFF_FFFF;
            4: return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [DVW-1:0] pick_b();
        case ($urandom_range(0, 9))
            0: return 24'h00_0001;
            1: return 24'hFF_FFFF;
            2: return 24'h80_0000;
            3: return 24'h7F_FFFF;
            4: return 24'h00_0000;
            5: return {16'h0000, 8'($urandom())};
            default: return 24'($urandom());
        endcase
    endfunction

    task automatic send(input logic en, input logic stb, input logic [W-1:0] a,
                        input logic [DVW-1:0] b, input logic [TW-1:0] tag, input exp_t e);
        @(posedge clock); #1;
        enable = en; input_strobe = stb; dividend = a; divisor = b; input_tag = tag;
        if (en && stb) begin
            e.due = en_cnt + LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clock); #1;
        enable = 1'b1; input_strobe = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, need 0", exp_q.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (quotient !== 32'd0 || remainder !== 32'd0 || output_tag !== 8'd0 ||
            div_by_zero !== 1'b0 || overflow !== 1'b0 || output_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s: got q=%h r=%h tag=%h dbz=%b ovf=%b stb=%b, need all 0",
                     name, quotient, remainder, output_tag, div_by_zero, overflow, output_strobe);
        end
    endtask

    // Output monitor: scoreboard compare on strobe, silence and stability on stall
    always @(negedge clock) begin
        if (output_strobe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got q=%h tag=%h, need no strobe", quotient, output_tag);
            end else begin
                cur_e = exp_q.pop_front();
                if (quotient !== cur_e.q || remainder !== cur_e.r || output_tag !== cur_e.tag ||
                    div_by_zero !== cur_e.dbz || overflow !== cur_e.ovf || en_cnt != cur_e.due) begin
                    errors++;
                    $display("FAIL result: got q=%h r=%h tag=%h dbz=%b ovf=%b cyc=%0d, need q=%h r=%h tag=%h dbz=%b ovf=%b cyc=%0d",
                             quotient, remainder, output_tag, div_by_zero, overflow, en_cnt,
                             cur_e.q, cur_e.r, cur_e.tag, cur_e.dbz, cur_e.ovf, cur_e.due);
                end
            end
        end
        if (reset_n && !enable) begin
            checks++;
            if (output_strobe !== 1'b0 ||
                (prev_rst && !prev_en && (quotient !== prev_q || remainder !== prev_r ||
                 output_tag !== prev_tag || div_by_zero !== prev_dbz || overflow !== prev_ovf))) begin
                errors++;
                $display("FAIL stall_hold: got stb=%b q=%h r=%h tag=%h, need stb=0 q=%h r=%h tag=%h",
                         output_strobe, quotient, remainder, output_tag, prev_q, prev_r, prev_tag);
            end
        end
        prev_q = quotient; prev_r = remainder; prev_tag = output_tag;
        prev_dbz = div_by_zero; prev_ovf = overflow;
        prev_en = enable; prev_rst = reset_n;
    end

    initial begin
        exp_t e;
        vecs[0]  = '{32'd100,       24'd7,       8'h11, 32'd14,        32'd2,         1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FF9C, 24'd7,       8'h12, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{32'd100,       24'hFF_FFF9, 8'h13, 32'hFFFF_FFF2, 32'd2,         1'b0, 1'b0};
        vecs[3]  = '{32'hFFFF_FF9C, 24'hFF_FFF9, 8'h14, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'd5,         24'd0,       8'h15, 32'h7FFF_FFFF, 32'd5,         1'b1, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFB, 24'd0,       8'h16, 32'h8000_0000, 32'hFFFF_FFFB, 1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 24'hFF_FFFF, 8'h17, 32'h7FFF_FFFF, 32'd0,         1'b0, 1'b1};
        vecs[7]  = '{32'd0,         24'd5,       8'h18, 32'd0,         32'd0,         1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0000, 24'd1,       8'h19, 32'h8000_0000, 32'd0,         1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 24'hFF_FFFE, 8'h1A, 32'h4000_0000, 32'd0,         1'b0, 1'b0};
        vecs[10] = '{32'd7,         24'hFF_FFF8, 8'h1B, 32'd0,         32'd7,         1'b0, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 24'h7F_FFFF, 8'h1C, 32'd256,       32'd255,       1'b0, 1'b0};
        vecs[12] = '{32'h8000_0000, 24'h80_0000, 8'h1D, 32'd256,       32'd0,         1'b0, 1'b0};
        vecs[13] = '{32'd0,         24'd0,       8'h1E, 32'h7FFF_FFFF, 32'd0,         1'b1, 1'b0};
        vecs[14] = '{32'hFFFF_FFF9, 24'd2,       8'h1F, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};

        // Reset state, then idle outputs before the first result
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset_outputs");
        @(posedge clock); #1;
        reset_n = 1'b1; enable = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_zero("idle_after_reset");

        // Directed table, single isolated first op then back-to-back
        for (int i = 0; i < 15; i++) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].dbz, vecs[i].ovf, 0};
            send(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].tag, e);
        end
        drain();

        // Back-to-back random traffic with corner operands
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] a;
            logic [DVW-1:0] b;
            logic [TW-1:0] t;
            a = pick_a(); b = pick_b(); t = 8'($urandom());
            send(1'b1, 1'b1, a, b, t, model(a, b, t));
        end
        drain();

        // Random stalls with strobes offered during stalled cycles
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] a;
            logic [DVW-1:0] b;
            logic [TW-1:0] t;
            logic en, stb;
            a = pick_a(); b = pick_b(); t = 8'($urandom());
            en = ($urandom_range(0, 99) >= 30);
            stb = ($urandom_range(0, 99) < 80);
            send(en, stb, a, b, t, model(a, b, t));
        end
        drain();

        // Reset with ten operations in flight, then a single 9 / 3
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 1'b1, 32'd1000 + 32'(i), 24'd3, 8'(i), model(32'd1000 + 32'(i), 24'd3, 8'(i)));
        end
        @(posedge clock); #1;
        reset_n = 1'b0; input_strobe = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check_zero("reset_in_flight");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        e = '{32'd3, 32'd0, 8'h5A, 1'b0, 1'b0, 0};
        send(1'b1, 1'b1, 32'd9, 24'd3, 8'h5A, e);
        drain();
        repeat (40) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
